// File: rtl/pcs_gen_pkg.sv
// pcs_gen_pkg: shared widths and 64b/66b, MII and pattern constants for the PCS stimulus generator.
// Also provides mii_encode(), which maps one 64b MII word plus its 8 control bits to a 66b block.
package pcs_gen_pkg;

    localparam int DATA_WIDTH           = 64;
    localparam int HDR_WIDTH            = 2;
    localparam int FRAME_WIDTH          = DATA_WIDTH + HDR_WIDTH;
    localparam int CONTROL_WIDTH        = 8;
    localparam int TRANSCODER_BLOCKS    = 4;
    localparam int TRANSCODER_WIDTH     = 257;
    localparam int TRANSCODER_HDR_WIDTH = 4;
    localparam int PROB                 = 30;

    localparam logic [HDR_WIDTH-1:0] SH_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    // Terminate block types T7..T0, indexed by the lane holding the terminate char.
    localparam logic [63:0] BT_TERM = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    localparam logic [7:0] PAT_DATA   = 8'hAA;
    localparam logic [7:0] PAT_ZERO   = 8'h00;
    localparam logic [3:0] PAT_NIBBLE = 4'hB;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;

    localparam logic [FRAME_WIDTH-1:0] IDLE_FRAME = {SH_CTRL, {8{CC_IDLE}}, BT_IDLE};
    localparam logic [FRAME_WIDTH-1:0] DATA_FRAME = {SH_DATA, {8{PAT_DATA}}};

    // Transcode of four idle blocks: block 0 compressed to 60b, flags all zero, header bit 0.
    localparam logic [TRANSCODER_WIDTH-1:0] TX_RESET =
        {{3{64'h1E}}, 56'h0, 4'hE, 4'h0, 1'b0};

    function automatic logic [FRAME_WIDTH-1:0] mii_encode(
        input logic [DATA_WIDTH-1:0]    txd,
        input logic [CONTROL_WIDTH-1:0] txc
    );
        logic [7:0]             idle_lane;
        logic [FRAME_WIDTH-1:0] blk;
        for (int m = 0; m < 8; m++) idle_lane[m] = txd[8*m +: 8] == MII_IDLE;
        blk = {SH_CTRL, {8{CC_ERROR}}, BT_IDLE};
        // Terminate in lane n: lanes above n must be idle, data lanes below n are packed after the type.
        for (int n = 0; n < 8; n++)
            if (txd[8*n +: 8] == MII_TERM && txc == 8'(8'hFF << n) &&
                (idle_lane & 8'(8'hFE << n)) == 8'(8'hFE << n))
                blk = {SH_CTRL, 56'(txd & ((64'd1 << (8*n)) - 64'd1)), BT_TERM[8*n +: 8]};
        if (txc == 8'h00)
            blk = {SH_DATA, txd};
        else if (txc == 8'hFF && &idle_lane)
            blk = IDLE_FRAME;
        else if (txc == 8'h01 && txd[7:0] == MII_START)
            blk = {SH_CTRL, txd[63:8], BT_START};
        return blk;
    endfunction

endpackage

// File: rtl/pcs_transcoder_257b.sv
// pcs_transcoder_257b: combinational 4x66b -> 257b transcoder.
// Ports: i_frame_0..3 (66b, {sh, payload}, frame 0 lowest), o_tx (257b transcoded block).
module pcs_transcoder_257b (
    input  logic [65:0]  i_frame_0,
    input  logic [65:0]  i_frame_1,
    input  logic [65:0]  i_frame_2,
    input  logic [65:0]  i_frame_3,
    output logic [256:0] o_tx
);
    import pcs_gen_pkg::*;

    logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] f;
    logic [TRANSCODER_BLOCKS-1:0][DATA_WIDTH-1:0]  p;
    logic [TRANSCODER_BLOCKS-1:0][59:0]            c;
    logic [TRANSCODER_HDR_WIDTH-1:0]               flags;

    always_comb begin
        f = {i_frame_3, i_frame_2, i_frame_1, i_frame_0};
        for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
            flags[k] = f[k][65:64] == SH_DATA;
            p[k]     = f[k][63:0];
            // The first control block drops type bits [7:4] to make room for the flag field.
            c[k]     = {f[k][63:8], f[k][3:0]};
        end
        o_tx = &flags   ? {p[3], p[2], p[1], p[0], 1'b1} :
               !flags[0] ? {p[3], p[2], p[1], c[0], flags, 1'b0} :
               !flags[1] ? {p[3], p[2], c[1], p[0], flags, 1'b0} :
               !flags[2] ? {p[3], c[2], p[1], p[0], flags, 1'b0} :
                           {c[3], p[2], p[1], p[0], flags, 1'b0};
    end

endmodule

// File: rtl/pcs_generator.sv
// pcs_generator: 100G BASE-R stimulus source; builds four 66b blocks per clock and their 257b transcode.
// Ports: clk, i_rst (async, active-high), i_txd/i_txc (MII word), i_data_sel_0 (pattern data select),
//   i_valid ([0] frame update, [1] 257b update), i_enable (1 pattern, 0 MII), i_random_0,
//   i_tx_test_mode (force idle), o_frame_0..3 (66b blocks, frame 0 oldest), o_tx_coded_f0 (257b).
// Define PCS_GEN_RANDOM_EN to build the LFSR and honour i_random_0; otherwise i_random_0 is ignored.
module pcs_generator (
    input  logic         clk,
    input  logic         i_rst,
    input  logic [63:0]  i_txd,
    input  logic [7:0]   i_txc,
    input  logic [3:0]   i_data_sel_0,
    input  logic [1:0]   i_valid,
    input  logic         i_enable,
    input  logic         i_random_0,
    input  logic         i_tx_test_mode,
    output logic [65:0]  o_frame_0,
    output logic [65:0]  o_frame_1,
    output logic [65:0]  o_frame_2,
    output logic [65:0]  o_frame_3,
    output logic [256:0] o_tx_coded_f0
);
    import pcs_gen_pkg::*;

    logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] frame_q, frame_d, pattern;
    logic [TRANSCODER_WIDTH-1:0]                   tx_q, tx_d, tx_next;
    logic [TRANSCODER_BLOCKS-1:0]                  ctrl_sel;

`ifdef PCS_GEN_RANDOM_EN
    logic [31:0]                  lfsr_q, lfsr_d;
    logic [TRANSCODER_BLOCKS-1:0] rand_ctrl;

    // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1.
    always_comb begin
        lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        for (int k = 0; k < TRANSCODER_BLOCKS; k++)
            rand_ctrl[k] = (lfsr_q[8*k +: 8] % 8'd100) < 8'(PROB);
        ctrl_sel = i_random_0 ? rand_ctrl : ~i_data_sel_0;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end
`else
    logic unused_random;
    assign unused_random = i_random_0;
    assign ctrl_sel      = ~i_data_sel_0;
`endif

    // MII mode shifts the new block in at frame 3, so frame 0 always holds the oldest block.
    always_comb begin
        for (int k = 0; k < TRANSCODER_BLOCKS; k++)
            pattern[k] = ctrl_sel[k] ? IDLE_FRAME : DATA_FRAME;
        frame_d = !i_valid[0]    ? frame_q :
                  i_tx_test_mode ? {TRANSCODER_BLOCKS{IDLE_FRAME}} :
                  i_enable       ? pattern :
                                   {mii_encode(i_txd, i_txc), frame_q[3:1]};
        tx_d    = i_valid[1] ? tx_next : tx_q;
    end

    // Transcoding the next-frame values keeps the 257b register aligned with the frames.
    pcs_transcoder_257b u_transcoder (
        .i_frame_0 (frame_d[0]),
        .i_frame_1 (frame_d[1]),
        .i_frame_2 (frame_d[2]),
        .i_frame_3 (frame_d[3]),
        .o_tx      (tx_next)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            frame_q <= {TRANSCODER_BLOCKS{IDLE_FRAME}};
            tx_q    <= TX_RESET;
        end else begin
            frame_q <= frame_d;
            tx_q    <= tx_d;
        end
    end

    assign o_frame_0     = frame_q[0];
    assign o_frame_1     = frame_q[1];
    assign o_frame_2     = frame_q[2];
    assign o_frame_3     = frame_q[3];
    assign o_tx_coded_f0 = tx_q;

endmodule

// File: tb/tb_pcs_generator.sv
// tb_pcs_generator: directed self-checking bench for pcs_generator (default build).
module tb_pcs_generator;

    localparam logic [65:0]  IDLE = {2'b10, 56'h0, 8'h1E};
    localparam logic [65:0]  DATA = {2'b01, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [65:0]  T0   = {2'b10, 56'h0, 8'h87};
    localparam logic [65:0]  ST   = {2'b10, 56'hAA_AAAA_AAAA_AAAA, 8'h78};
    localparam logic [65:0]  T2   = {2'b10, 40'h0, 16'hAAAA, 8'hAA};
    localparam logic [65:0]  DW   = {2'b01, 64'h0123_4567_89AB_CDEF};
    localparam logic [65:0]  ERR  = {2'b10, {8{7'h1E}}, 8'h1E};
    localparam logic [65:0]  T7   = {2'b10, 56'h11_2233_4455_6677, 8'hFF};
    localparam logic [63:0]  AA64 = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [256:0] TX_RST = {{3{64'h1E}}, 56'h0, 4'hE, 4'h0, 1'b0};
    localparam logic [256:0] TX_D = {64'h0123_4567_89AB_CDEF, 64'h0000_0000_00AA_AAAA,
                                     64'hAAAA_AAAA_AAAA_AA78, 56'h0, 4'h7, 4'b1000, 1'b0};
    localparam logic [256:0] TX_E = {{8{7'h1E}}, 8'h1E, 64'h1E, 64'h0123_4567_89AB_CDEF,
                                     56'h00_0000_0000_AAAA, 4'hA, 4'b0010, 1'b0};

    logic         clk = 1'b0;
    logic         i_rst;
    logic [63:0]  i_txd;
    logic [7:0]   i_txc;
    logic [3:0]   i_data_sel_0;
    logic [1:0]   i_valid;
    logic         i_enable;
    logic         i_random_0;
    logic         i_tx_test_mode;
    logic [65:0]  o_frame_0, o_frame_1, o_frame_2, o_frame_3;
    logic [256:0] o_tx_coded_f0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pcs_generator dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_txd          (i_txd),
        .i_txc          (i_txc),
        .i_data_sel_0   (i_data_sel_0),
        .i_valid        (i_valid),
        .i_enable       (i_enable),
        .i_random_0     (i_random_0),
        .i_tx_test_mode (i_tx_test_mode),
        .o_frame_0      (o_frame_0),
        .o_frame_1      (o_frame_1),
        .o_frame_2      (o_frame_2),
        .o_frame_3      (o_frame_3),
        .o_tx_coded_f0  (o_tx_coded_f0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] c);
        i_txd = d;
        i_txc = c;
        step();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_txd = '0;
        i_txc = '0;
        i_data_sel_0 = 4'hF;
        i_valid = 2'b11;
        i_enable = 1'b1;
        i_random_0 = 1'b0;
        i_tx_test_mode = 1'b0;
        repeat (2) step();
        total++;
        if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3} !== {4{IDLE}})
            $display("FAIL reset_frames got %h want %h", {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, {4{IDLE}});
        else passed++;
        total++;
        if (o_tx_coded_f0 !== TX_RST)
            $display("FAIL reset_tx got %h want %h", o_tx_coded_f0, TX_RST);
        else passed++;
        i_rst = 1'b0;
    endtask

    task automatic test_pattern();
        i_data_sel_0 = 4'b0000;
        step();
        total++;
        if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3} !== {4{IDLE}})
            $display("FAIL pat_idle_frames got %h want %h", {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, {4{IDLE}});
        else passed++;
        total++;
        if (o_tx_coded_f0[4:0] !== 5'b00000)
            $display("FAIL pat_idle_hdr got %b want 00000", o_tx_coded_f0[4:0]);
        else passed++;
        total++;
        if (o_tx_coded_f0[8:5] !== 4'hE)
            $display("FAIL pat_idle_type got %h want e", o_tx_coded_f0[8:5]);
        else passed++;
        i_data_sel_0 = 4'b1111;
        step();
        total++;
        if (o_tx_coded_f0[0] !== 1'b1)
            $display("FAIL pat_data_hdr got %b want 1", o_tx_coded_f0[0]);
        else passed++;
        total++;
        if (o_tx_coded_f0[256:1] !== {4{AA64}})
            $display("FAIL pat_data_payload got %h want %h", o_tx_coded_f0[256:1], {4{AA64}});
        else passed++;
        total++;
        if (o_frame_2 !== DATA)
            $display("FAIL pat_data_frame2 got %h want %h", o_frame_2, DATA);
        else passed++;
        i_data_sel_0 = 4'b0001;
        step();
        total++;
        if ({o_frame_0, o_frame_1} !== {DATA, IDLE})
            $display("FAIL pat_0001_frames got %h want %h", {o_frame_0, o_frame_1}, {DATA, IDLE});
        else passed++;
        total++;
        if (o_tx_coded_f0[128:69] !== {56'h0, 4'hE})
            $display("FAIL pat_0001_comp got %h want %h", o_tx_coded_f0[128:69], {56'h0, 4'hE});
        else passed++;
        total++;
        if (o_tx_coded_f0 !== {64'h1E, 64'h1E, 56'h0, 4'hE, AA64, 4'b0001, 1'b0})
            $display("FAIL pat_0001_tx got %h want %h", o_tx_coded_f0, {64'h1E, 64'h1E, 56'h0, 4'hE, AA64, 4'b0001, 1'b0});
        else passed++;
        i_data_sel_0 = 4'b1000;
        step();
        total++;
        if (o_tx_coded_f0 !== {AA64, 64'h1E, 64'h1E, 56'h0, 4'hE, 4'b1000, 1'b0})
            $display("FAIL pat_1000_tx got %h want %h", o_tx_coded_f0, {AA64, 64'h1E, 64'h1E, 56'h0, 4'hE, 4'b1000, 1'b0});
        else passed++;
        i_data_sel_0 = 4'b0111;
        step();
        total++;
        if (o_tx_coded_f0 !== {56'h0, 4'hE, AA64, AA64, AA64, 4'b0111, 1'b0})
            $display("FAIL pat_0111_tx got %h want %h", o_tx_coded_f0, {56'h0, 4'hE, AA64, AA64, AA64, 4'b0111, 1'b0});
        else passed++;
    endtask

    task automatic test_test_mode();
        i_data_sel_0 = 4'b1111;
        i_tx_test_mode = 1'b1;
        step();
        total++;
        if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3} !== {4{IDLE}})
            $display("FAIL testmode_frames got %h want %h", {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, {4{IDLE}});
        else passed++;
        total++;
        if (o_tx_coded_f0 !== TX_RST)
            $display("FAIL testmode_tx got %h want %h", o_tx_coded_f0, TX_RST);
        else passed++;
        i_tx_test_mode = 1'b0;
    endtask

    task automatic test_mii();
        i_enable = 1'b0;
        push(64'h0707_0707_0707_07FD, 8'hFF);
        total++;
        if (o_frame_3 !== T0)
            $display("FAIL mii_t0 got %h want %h", o_frame_3, T0);
        else passed++;
        push(64'hAAAA_AAAA_AAAA_AAFB, 8'h01);
        total++;
        if ({o_frame_2, o_frame_3} !== {T0, ST})
            $display("FAIL mii_start got %h want %h", {o_frame_2, o_frame_3}, {T0, ST});
        else passed++;
        push(64'h0707_0707_07FD_AAAA, 8'hFC);
        total++;
        if (o_frame_3 !== T2)
            $display("FAIL mii_t2 got %h want %h", o_frame_3, T2);
        else passed++;
        push(64'h0123_4567_89AB_CDEF, 8'h00);
        total++;
        if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3} !== {T0, ST, T2, DW})
            $display("FAIL mii_shift got %h want %h", {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, {T0, ST, T2, DW});
        else passed++;
        total++;
        if (o_tx_coded_f0 !== TX_D)
            $display("FAIL mii_tx got %h want %h", o_tx_coded_f0, TX_D);
        else passed++;
    endtask

    task automatic test_hold();
        i_valid = 2'b00;
        i_enable = 1'b1;
        i_data_sel_0 = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            push(64'h0707_0707_0707_0707 + 64'(i), 8'hFF);
            total++;
            if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3, o_tx_coded_f0} !== {T0, ST, T2, DW, TX_D})
                $display("FAIL hold_cycle%0d frames %h tx %h", i, {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, o_tx_coded_f0);
            else passed++;
        end
        i_enable = 1'b0;
        i_valid = 2'b01;
        push(64'h0707_0707_0707_0707, 8'hFF);
        total++;
        if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3} !== {ST, T2, DW, IDLE})
            $display("FAIL hold_frames_only got %h want %h", {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, {ST, T2, DW, IDLE});
        else passed++;
        total++;
        if (o_tx_coded_f0 !== TX_D)
            $display("FAIL hold_tx_only got %h want %h", o_tx_coded_f0, TX_D);
        else passed++;
        i_valid = 2'b11;
        push(64'h0, 8'h0F);
        total++;
        if (o_frame_3 !== ERR)
            $display("FAIL mii_error got %h want %h", o_frame_3, ERR);
        else passed++;
        total++;
        if (o_tx_coded_f0 !== TX_E)
            $display("FAIL error_tx got %h want %h", o_tx_coded_f0, TX_E);
        else passed++;
        push(64'hFD11_2233_4455_6677, 8'h80);
        total++;
        if (o_frame_3 !== T7)
            $display("FAIL mii_t7 got %h want %h", o_frame_3, T7);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        #1;
        i_rst = 1'b1;
        #1;
        total++;
        if ({o_frame_0, o_frame_1, o_frame_2, o_frame_3} !== {4{IDLE}})
            $display("FAIL midrun_frames got %h want %h", {o_frame_0, o_frame_1, o_frame_2, o_frame_3}, {4{IDLE}});
        else passed++;
        total++;
        if (o_tx_coded_f0 !== TX_RST)
            $display("FAIL midrun_tx got %h want %h", o_tx_coded_f0, TX_RST);
        else passed++;
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_test_mode();
        test_mii();
        test_hold();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
